// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter sharing one BRAM port (1-cycle read latency), with per-requester response buffering.
// Optional feature macro: BRAM_ARB_ROUND_ROBIN_EN (round-robin on contention; default is fixed priority to requester 0).
module bram_port_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [1:0]                       req_valid,
  output logic [1:0]                       req_ready,
  input  logic [1:0][ADDR_WIDTH-1:0]       req_addr,
  input  logic [1:0][STRB_WIDTH-1:0]       req_we,
  input  logic [1:0][DATA_WIDTH-1:0]       req_wdata,
  output logic [1:0]                       rsp_valid,
  input  logic [1:0]                       rsp_ready,
  output logic [1:0][DATA_WIDTH-1:0]       rsp_data,
  output logic                             bram_en,
  output logic [STRB_WIDTH-1:0]            bram_we,
  output logic [ADDR_WIDTH-1:0]            bram_addr,
  output logic [DATA_WIDTH-1:0]            bram_wrdata,
  input  logic [DATA_WIDTH-1:0]            bram_rddata
);

  // Handshakes: a request transfers in a cycle where req_valid[i] && req_ready[i];
  // a response transfers where rsp_valid[i] && rsp_ready[i]. Neither side may
  // make valid depend on ready; req_ready is combinational from req_valid.

  logic [1:0]                 r_rsp_valid;
  logic [1:0]                 r_first;
  logic [1:0][DATA_WIDTH-1:0] r_buf;
  logic [1:0]                 w_elig;
  logic [1:0]                 w_grant;
  logic                       w_sel;

`ifdef BRAM_ARB_ROUND_ROBIN_EN
  logic r_last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last <= 1'b1;
    end else if (|w_grant) begin
      r_last <= w_grant[1];
    end
  end
`endif

  always_comb begin
    w_elig  = req_valid & (~r_rsp_valid | rsp_ready);
    w_grant = 2'b00;
    if (rstn) begin
      if (&w_elig) begin
`ifdef BRAM_ARB_ROUND_ROBIN_EN
        w_grant = r_last ? 2'b01 : 2'b10;
`else
        w_grant = 2'b01;
`endif
      end else begin
        w_grant = w_elig;
      end
    end
  end

  assign w_sel       = w_grant[1];
  assign req_ready   = w_grant;
  assign bram_en     = |w_grant;
  assign bram_addr   = req_addr[w_sel];
  assign bram_we     = bram_en ? req_we[w_sel] : '0;
  assign bram_wrdata = req_wdata[w_sel];
  assign rsp_valid   = r_rsp_valid;

  // r_first marks the cycle where BRAM output still belongs to this requester.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rsp_data[i] = r_first[i] ? bram_rddata : r_buf[i];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rsp_valid <= 2'b00;
      r_first     <= 2'b00;
      r_buf       <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_grant[i]) begin
          r_rsp_valid[i] <= 1'b1;
          r_first[i]     <= 1'b1;
        end else if (r_rsp_valid[i] && rsp_ready[i]) begin
          r_rsp_valid[i] <= 1'b0;
          r_first[i]     <= 1'b0;
        end else if (r_first[i]) begin
          r_buf[i]   <= bram_rddata;
          r_first[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed, table-driven bench for bram_port_arbiter with a behavioural BRAM (read-first, 1-cycle latency).
module tb_bram_port_arbiter;
  localparam int DW = 64;
  localparam int AW = 16;
  localparam int SW = DW / 8;

  logic               clk;
  logic               rstn;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [1:0][AW-1:0] req_addr;
  logic [1:0][SW-1:0] req_we;
  logic [1:0][DW-1:0] req_wdata;
  logic [1:0]         rsp_valid;
  logic [1:0]         rsp_ready;
  logic [1:0][DW-1:0] rsp_data;
  logic               bram_en;
  logic [SW-1:0]      bram_we;
  logic [AW-1:0]      bram_addr;
  logic [DW-1:0]      bram_wrdata;
  logic [DW-1:0]      bram_rddata;
  logic               tb_preload;
  logic [DW-1:0]      mem [256];

  int n_pass;
  int n_total;

  bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wrdata(bram_wrdata), .bram_rddata(bram_rddata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tb_preload) begin
      mem[8'h10] <= 64'hA5A5;
      mem[8'h01] <= 64'h1111;
      mem[8'h02] <= 64'h2222;
      mem[8'h04] <= 64'h0;
    end else if (bram_en) begin
      for (int b = 0; b < SW; b++) begin
        if (bram_we[b]) mem[bram_addr[7:0]][8*b +: 8] <= bram_wrdata[8*b +: 8];
      end
      bram_rddata <= mem[bram_addr[7:0]];
    end
  end

  typedef struct {
    logic [1:0]    vld;
    logic [1:0]    rdy;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [SW-1:0] we1;
    logic [DW-1:0] wd1;
    logic [1:0]    x_rr;
    logic [1:0]    x_rv;
    logic          x_en;
    logic [AW-1:0] x_addr;
    logic [SW-1:0] x_we;
    logic          c0;
    logic [DW-1:0] x_d0;
    logic          c1;
    logic [DW-1:0] x_d1;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic [1:0] vld, logic [1:0] rdy, logic [AW-1:0] a0, logic [AW-1:0] a1,
                              logic [SW-1:0] we1, logic [DW-1:0] wd1, logic [1:0] x_rr, logic [1:0] x_rv,
                              logic x_en, logic [AW-1:0] x_addr, logic [SW-1:0] x_we,
                              logic c0, logic [DW-1:0] x_d0, logic c1, logic [DW-1:0] x_d1);
    vec_t v;
    v.vld = vld; v.rdy = rdy; v.a0 = a0; v.a1 = a1; v.we1 = we1; v.wd1 = wd1;
    v.x_rr = x_rr; v.x_rv = x_rv; v.x_en = x_en; v.x_addr = x_addr; v.x_we = x_we;
    v.c0 = c0; v.x_d0 = x_d0; v.c1 = c1; v.x_d1 = x_d1;
    return v;
  endfunction

  // scoreboard compare
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // driver: inputs change on the falling edge; outputs are sampled 1ns later
  task automatic drive(input logic [1:0] vld, input logic [1:0] rdy, input logic [AW-1:0] a0,
                       input logic [AW-1:0] a1, input logic [SW-1:0] we1, input logic [DW-1:0] wd1);
    @(negedge clk);
    req_valid = vld;
    rsp_ready = rdy;
    req_addr[0] = a0;
    req_addr[1] = a1;
    req_we[0] = '0;
    req_we[1] = we1;
    req_wdata[0] = 64'hFFFF_0000;
    req_wdata[1] = wd1;
    #1;
  endtask

  task automatic pulse_reset;
    @(negedge clk);
    rstn = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    #1;
    chk("rst_rsp_valid", {62'b0, rsp_valid}, 64'd0);
    chk("rst_req_ready", {62'b0, req_ready}, 64'd0);
    chk("rst_bram_en", {63'b0, bram_en}, 64'd0);
    chk("rst_bram_we", {56'b0, bram_we}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    rstn = 1'b1;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rstn = 1'b0;
    tb_preload = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_addr = '0;
    req_we = '0;
    req_wdata = '0;

    // reset-state checks with requests asserted during reset
    repeat (2) @(posedge clk);
    pulse_reset();
    tb_preload = 1'b0;

    vecs[0]  = mk(2'b01, 2'b11, 16'h0010, 16'h0000, 8'h00, 64'h0,    2'b01, 2'b00, 1'b1, 16'h0010, 8'h00, 1'b0, 64'h0,    1'b0, 64'h0);
    vecs[1]  = mk(2'b00, 2'b11, 16'h0000, 16'h0000, 8'h00, 64'h0,    2'b00, 2'b01, 1'b0, 16'h0000, 8'h00, 1'b1, 64'hA5A5, 1'b0, 64'h0);
    vecs[2]  = mk(2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 64'h0,    2'b00, 2'b00, 1'b0, 16'h0000, 8'h00, 1'b0, 64'h0,    1'b0, 64'h0);
    vecs[3]  = mk(2'b01, 2'b00, 16'h0001, 16'h0000, 8'h00, 64'h0,    2'b01, 2'b00, 1'b1, 16'h0001, 8'h00, 1'b0, 64'h0,    1'b0, 64'h0);
    vecs[4]  = mk(2'b11, 2'b00, 16'h0001, 16'h0002, 8'h00, 64'h0,    2'b10, 2'b01, 1'b1, 16'h0002, 8'h00, 1'b1, 64'h1111, 1'b0, 64'h0);
    vecs[5]  = mk(2'b11, 2'b00, 16'h0001, 16'h0002, 8'h00, 64'h0,    2'b00, 2'b11, 1'b0, 16'h0000, 8'h00, 1'b1, 64'h1111, 1'b1, 64'h2222);
    vecs[6]  = mk(2'b11, 2'b00, 16'h0001, 16'h0002, 8'h00, 64'h0,    2'b00, 2'b11, 1'b0, 16'h0000, 8'h00, 1'b1, 64'h1111, 1'b1, 64'h2222);
    vecs[7]  = mk(2'b00, 2'b11, 16'h0000, 16'h0000, 8'h00, 64'h0,    2'b00, 2'b11, 1'b0, 16'h0000, 8'h00, 1'b1, 64'h1111, 1'b1, 64'h2222);
    vecs[8]  = mk(2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 64'h0,    2'b00, 2'b00, 1'b0, 16'h0000, 8'h00, 1'b0, 64'h0,    1'b0, 64'h0);
    vecs[9]  = mk(2'b10, 2'b11, 16'h0000, 16'h0004, 8'hFF, 64'hDEAD, 2'b10, 2'b00, 1'b1, 16'h0004, 8'hFF, 1'b0, 64'h0,    1'b0, 64'h0);
    vecs[10] = mk(2'b10, 2'b11, 16'h0000, 16'h0004, 8'h00, 64'h0,    2'b10, 2'b10, 1'b1, 16'h0004, 8'h00, 1'b0, 64'h0,    1'b0, 64'h0);
    vecs[11] = mk(2'b00, 2'b11, 16'h0000, 16'h0000, 8'h00, 64'h0,    2'b00, 2'b10, 1'b0, 16'h0000, 8'h00, 1'b0, 64'h0,    1'b1, 64'hDEAD);
    vecs[12] = mk(2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 64'h0,    2'b00, 2'b00, 1'b0, 16'h0000, 8'h00, 1'b0, 64'h0,    1'b0, 64'h0);
    vecs[13] = mk(2'b00, 2'b11, 16'h0055, 16'h0066, 8'hFF, 64'hBEEF, 2'b00, 2'b00, 1'b0, 16'h0000, 8'h00, 1'b0, 64'h0,    1'b0, 64'h0);
    vecs[14] = mk(2'b01, 2'b11, 16'h0010, 16'h0000, 8'h00, 64'h0,    2'b01, 2'b00, 1'b1, 16'h0010, 8'h00, 1'b0, 64'h0,    1'b0, 64'h0);
    vecs[15] = mk(2'b01, 2'b11, 16'h0001, 16'h0000, 8'h00, 64'h0,    2'b01, 2'b01, 1'b1, 16'h0001, 8'h00, 1'b1, 64'hA5A5, 1'b0, 64'h0);
    vecs[16] = mk(2'b00, 2'b11, 16'h0000, 16'h0000, 8'h00, 64'h0,    2'b00, 2'b01, 1'b0, 16'h0000, 8'h00, 1'b1, 64'h1111, 1'b0, 64'h0);
    vecs[17] = mk(2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 64'h0,    2'b00, 2'b00, 1'b0, 16'h0000, 8'h00, 1'b0, 64'h0,    1'b0, 64'h0);

    for (int k = 0; k < 18; k++) begin
      drive(vecs[k].vld, vecs[k].rdy, vecs[k].a0, vecs[k].a1, vecs[k].we1, vecs[k].wd1);
      chk($sformatf("v%0d_req_ready", k), {62'b0, req_ready}, {62'b0, vecs[k].x_rr});
      chk($sformatf("v%0d_rsp_valid", k), {62'b0, rsp_valid}, {62'b0, vecs[k].x_rv});
      chk($sformatf("v%0d_bram_en", k), {63'b0, bram_en}, {63'b0, vecs[k].x_en});
      chk($sformatf("v%0d_bram_we", k), {56'b0, bram_we}, {56'b0, vecs[k].x_we});
      if (vecs[k].x_en) chk($sformatf("v%0d_bram_addr", k), {48'b0, bram_addr}, {48'b0, vecs[k].x_addr});
      if (vecs[k].c0) chk($sformatf("v%0d_rsp_data0", k), rsp_data[0], vecs[k].x_d0);
      if (vecs[k].c1) chk($sformatf("v%0d_rsp_data1", k), rsp_data[1], vecs[k].x_d1);
    end

    // contention: both requesting every cycle from a fresh reset
    pulse_reset();
    begin
      logic [1:0] prev_g;
      logic [1:0] exp_g;
      prev_g = 2'b00;
      for (int k = 0; k < 4; k++) begin
        drive(2'b11, 2'b11, 16'h0010, 16'h0001, 8'h00, 64'h0);
`ifdef BRAM_ARB_ROUND_ROBIN_EN
        exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
        exp_g = 2'b01;
`endif
        chk($sformatf("arb%0d_req_ready", k), {62'b0, req_ready}, {62'b0, exp_g});
        chk($sformatf("arb%0d_rsp_valid", k), {62'b0, rsp_valid}, {62'b0, prev_g});
        if (prev_g == 2'b01) chk($sformatf("arb%0d_rsp_data0", k), rsp_data[0], 64'hA5A5);
        if (prev_g == 2'b10) chk($sformatf("arb%0d_rsp_data1", k), rsp_data[1], 64'h1111);
        prev_g = exp_g;
      end
      drive(2'b00, 2'b11, 16'h0, 16'h0, 8'h00, 64'h0);
      chk("arb_drain_rsp_valid", {62'b0, rsp_valid}, {62'b0, prev_g});
      drive(2'b00, 2'b00, 16'h0, 16'h0, 8'h00, 64'h0);
      chk("arb_idle_rsp_valid", {62'b0, rsp_valid}, 64'd0);
    end

    // fill both response buffers, then reset mid-operation
    drive(2'b01, 2'b00, 16'h0001, 16'h0000, 8'h00, 64'h0);
    chk("fill_a_req_ready", {62'b0, req_ready}, 64'd1);
    drive(2'b10, 2'b00, 16'h0000, 16'h0002, 8'h00, 64'h0);
    chk("fill_b_req_ready", {62'b0, req_ready}, 64'd2);
    drive(2'b00, 2'b00, 16'h0, 16'h0, 8'h00, 64'h0);
    chk("fill_c_rsp_valid", {62'b0, rsp_valid}, 64'd3);
    chk("fill_c_rsp_data0", rsp_data[0], 64'h1111);
    chk("fill_c_rsp_data1", rsp_data[1], 64'h2222);
    drive(2'b00, 2'b00, 16'h0, 16'h0, 8'h00, 64'h0);
    chk("fill_d_rsp_valid", {62'b0, rsp_valid}, 64'd3);
    chk("fill_d_rsp_data1", rsp_data[1], 64'h2222);
    pulse_reset();
    rsp_ready = 2'b11;
    for (int k = 0; k < 3; k++) begin
      drive(2'b00, 2'b11, 16'h0, 16'h0, 8'h00, 64'h0);
      chk($sformatf("post_rst%0d_rsp_valid", k), {62'b0, rsp_valid}, 64'd0);
    end
    drive(2'b01, 2'b11, 16'h0002, 16'h0000, 8'h00, 64'h0);
    chk("post_rst_grant", {62'b0, req_ready}, 64'd1);
    drive(2'b00, 2'b11, 16'h0, 16'h0, 8'h00, 64'h0);
    chk("post_rst_rsp_valid", {62'b0, rsp_valid}, 64'd1);
    chk("post_rst_rsp_data0", rsp_data[0], 64'h2222);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL set BRAM word width; STRB_WIDTH = DATA_WIDTH/8.
REQ-002 Parameter ADDR_WIDTH, default 16, SHALL set BRAM word-address width.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL be updated on posedge clk.
REQ-004 rstn  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_valid  input  [1:0]  SHALL flag a pending request per requester i (0, 1).
REQ-006 req_ready  output  [1:0]  SHALL flag acceptance of requester i's request this cycle.
REQ-007 req_addr  input  [1:0][ADDR_WIDTH-1:0]  SHALL carry the word address per requester.
REQ-008 req_we  input  [1:0][STRB_WIDTH-1:0]  SHALL carry byte write enables; all-zero means read.
REQ-009 req_wdata  input  [1:0][DATA_WIDTH-1:0]  SHALL carry write data per requester.
REQ-010 rsp_valid  output  [1:0]  SHALL flag a response pending for requester i.
REQ-011 rsp_ready  input  [1:0]  SHALL flag requester i consuming its response.
REQ-012 rsp_data  output  [1:0][DATA_WIDTH-1:0]  SHALL carry read data (undefined for write responses).
REQ-013 bram_en, bram_we[STRB_WIDTH], bram_addr[ADDR_WIDTH], bram_wrdata[DATA_WIDTH] outputs and bram_rddata[DATA_WIDTH] input SHALL drive one BRAM port with 1-cycle read latency.

Function
REQ-014 Requester i SHALL be eligible when req_valid[i] && (!rsp_valid[i] || rsp_ready[i]).
REQ-015 At most one eligible requester SHALL be granted per cycle; req_ready[i] SHALL equal grant[i], combinational.
REQ-016 On grant to i: bram_en=1, bram_addr=req_addr[i], bram_we=req_we[i], bram_wrdata=req_wdata[i]; with no grant bram_en=0 and bram_we=0.
REQ-017 Every accepted request (read or write) SHALL raise rsp_valid[i] exactly one cycle later.
REQ-018 rsp_valid[i] SHALL hold until rsp_valid[i] && rsp_ready[i]; a grant to i in the consuming cycle SHALL keep rsp_valid[i]=1 with new data (back-to-back, one response per cycle per requester).
REQ-019 In the first cycle of rsp_valid[i], rsp_data[i] SHALL equal bram_rddata; if not consumed that cycle, bram_rddata SHALL be latched into a per-requester buffer and rsp_data[i] SHALL come from the buffer until consumed.
REQ-020 The buffer of requester i SHALL NOT be overwritten by BRAM reads issued for the other requester.
REQ-021 Arbitration state SHALL be a 1-bit last-grant pointer, updated to i only on a grant to i.
REQ-022 Request inputs with req_valid=0 SHALL be ignored; req_addr/we/wdata changes while not granted SHALL have no effect.

Reset
REQ-023 While rstn=0: req_ready=0, rsp_valid=0, bram_en=0, bram_we=0, buffers marked empty, last-grant pointer=1 (requester 0 wins first).
REQ-024 Reset asserted mid-operation SHALL discard all pending responses and latched data; no response SHALL appear after reset release without a new grant.

Configuration
REQ-025 With macro BRAM_ARB_ROUND_ROBIN_EN defined, when both requesters are eligible the one not equal to the last-grant pointer SHALL be granted.
REQ-026 Without BRAM_ARB_ROUND_ROBIN_EN, requester 0 SHALL always win when both are eligible; the pointer SHALL be omitted.

Verification
REQ-027 Reset, then req_valid=01, req 0 read addr 0x0010 (BRAM holds 0xA5A5) with rsp_ready=1 -> bram_en=1 addr 0x0010 same cycle; rsp_valid[0]=1, rsp_data[0]=0xA5A5 next cycle.
REQ-028 Both valid every cycle, rsp_ready=11, macro defined -> grants alternate 0,1,0,1; macro undefined -> grant always 0, req_ready[1]=0.
REQ-029 Requester 0 reads 0x0001 (0x1111), rsp_ready[0]=0 for 3 cycles while requester 1 reads 0x0002 (0x2222) -> rsp_data[0] stays 0x1111, rsp_data[1]=0x2222; req_ready[0]=0 throughout stall.
REQ-030 Requester 1 writes 0xDEAD to 0x0004 with req_we=all-ones, then reads 0x0004 -> write response then rsp_data[1]=0xDEAD; bram_we=0 on the read cycle.
REQ-031 rstn pulsed low while rsp_valid=11 and buffers full -> rsp_valid=00 immediately, remains 00 after release until next grant.
